// File: rtl/control_unit.sv
// Moore fetch/decode/execute controller: one instruction per Fetch, LOAD takes 4 cycles, others 3.
// Outputs decode combinationally from state and IR; no backpressure, HALT parks until reset.
module control_unit #(
  parameter int AW = 8,
  parameter int RW = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [15:0]   IR,
  output logic          PC_clr,
  output logic          PC_up,
  output logic          IR_ld,
  output logic [AW-1:0] D_addr,
  output logic          D_wr,
  output logic          RF_s,
  output logic [RW-1:0] RF_W_addr,
  output logic          RF_W_en,
  output logic [RW-1:0] RF_Ra_addr,
  output logic [RW-1:0] RF_Rb_addr,
  output logic [2:0]    ALU_s0,
  output logic [3:0]    OutState
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  state_t state, next_state;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_INIT;
    else        state <= next_state;
  end

  always_comb begin
    next_state = S_INIT;
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 1'b0;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    ALU_s0     = 3'd0;
    case (state)
      S_INIT: begin
        PC_clr     = 1'b1;
        next_state = S_FETCH;
      end
      S_FETCH: begin
        IR_ld      = 1'b1;
        PC_up      = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        // Undefined opcodes fall through to NoOp.
        case (IR[15:12])
          4'h1:    next_state = S_STORE;
          4'h2:    next_state = S_LOADA;
          4'h3:    next_state = S_ADD;
          4'h4:    next_state = S_SUB;
          4'h5:    next_state = S_HALT;
          default: next_state = S_NOOP;
        endcase
      end
      S_NOOP: next_state = S_FETCH;
      S_LOADA: begin
        D_addr     = AW'(IR[11:4]);
        next_state = S_LOADB;
      end
      S_LOADB: begin
        D_addr     = AW'(IR[11:4]);
        RF_s       = 1'b1;
        RF_W_addr  = RW'(IR[3:0]);
        RF_W_en    = 1'b1;
        next_state = S_FETCH;
      end
      S_STORE: begin
        D_addr     = AW'(IR[11:4]);
        RF_Ra_addr = RW'(IR[3:0]);
        D_wr       = 1'b1;
        next_state = S_FETCH;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = RW'(IR[11:8]);
        RF_Rb_addr = RW'(IR[7:4]);
        RF_W_addr  = RW'(IR[3:0]);
        RF_W_en    = 1'b1;
        ALU_s0     = (state == S_SUB) ? 3'd2 : 3'd1;
        next_state = S_FETCH;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_INIT;
    endcase
  end

  assign OutState = state;

endmodule
